div_issue_ctrl: RTL and testbench

- Wraps the pipelined signed divider for the fluid solver.
- Accepts tagged divide requests over valid/ready and issues at most one per cycle to the divider.
- Tracks each in-flight request through a pipeline matched to the divider's latency, handles divide-by-zero, and applies the remainder sign.
- Buffers results in a credit-protected response FIFO, because the divider has no backpressure.

---
 rtl/div_pkg.sv | 27 ++
 rtl/resp_fifo.sv | 58 +++++
 rtl/div_issue_ctrl.sv | 168 ++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types for the divider issue controller: tracking-pipeline entry and
// response record. Field widths come from the package defaults below; the
// controller's WIDTH/TAG_W parameters must match them.
package div_pkg;

  localparam int DIV_LATENCY_DEFAULT = 16;
  localparam int DIV_WIDTH_DEFAULT   = 32;
  localparam int DIV_TAG_W_DEFAULT   = 8;

  // One in-flight request, travelling alongside the divider's internal pipe.
  typedef struct packed {
    logic                         valid;
    logic [DIV_TAG_W_DEFAULT-1:0] tag;
    logic                         dbz;
    logic                         dividend_sign;
    logic [DIV_WIDTH_DEFAULT-1:0] dividend;
  } trk_t;

  // Finished result as stored in the response FIFO.
  typedef struct packed {
    logic [DIV_WIDTH_DEFAULT-1:0] quotient;
    logic [DIV_WIDTH_DEFAULT-1:0] remainder;
    logic [DIV_TAG_W_DEFAULT-1:0] tag;
    logic                         dbz;
  } rsp_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate flag. Storage is not reset.
module resp_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  rsp_t                     wr_data_i,
  input  logic                     rd_en_i,
  output rsp_t                     rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  rsp_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_wr, do_rd;

  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign full_o    = (count_o == PW'(DEPTH));
  assign empty_o   = (count_o == '0);
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted writes and reads.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers; cleared on reset so the FIFO starts empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue controller around the pipelined signed divider. Requests are accepted
// against a credit count covering both in-flight work and buffered results,
// so the non-stallable divider can never overrun the response FIFO.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH       = DIV_WIDTH_DEFAULT,
  parameter int TAG_W       = DIV_TAG_W_DEFAULT,
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT,
  parameter int FIFO_DEPTH  = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    req_valid_in,
  output logic                    req_ready_out,
  input  logic signed [WIDTH-1:0] req_dividend_in,
  input  logic signed [WIDTH-1:0] req_divisor_in,
  input  logic        [TAG_W-1:0] req_tag_in,
  output logic                    div_valid_out,
  output logic signed [WIDTH-1:0] div_dividend_out,
  output logic signed [WIDTH-1:0] div_divisor_out,
  input  logic                    div_valid_in,
  input  logic signed [WIDTH-1:0] div_quotient_in,
  input  logic        [WIDTH-1:0] div_remainder_in,
  output logic                    rsp_valid_out,
  input  logic                    rsp_ready_in,
  output logic signed [WIDTH-1:0] rsp_quotient_out,
  output logic signed [WIDTH-1:0] rsp_remainder_out,
  output logic        [TAG_W-1:0] rsp_tag_out,
  output logic                    rsp_dbz_out,
  output logic                    err_out
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int BLNK_W = $clog2(DIV_LATENCY + 1);

  logic              accept, pop;
  logic              req_ready_q, req_ready_d;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic [BLNK_W-1:0] blank_q, blank_d;
  logic              err_q, err_d;
  logic              req_dbz;

  trk_t              trk_q [DIV_LATENCY];
  trk_t              trk_in, trk_tail;

  rsp_t              fifo_wdata, fifo_rdata;
  logic              fifo_wr, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic              unused_fifo_cnt;

  assign req_ready_out = req_ready_q;
  assign accept        = req_valid_in & req_ready_q;
  assign pop           = rsp_valid_out & rsp_ready_in;
  assign req_dbz       = (req_divisor_in == '0);
  assign err_out       = err_q;

  // Issue path: a zero divisor is replaced by 0/1 so the slot is still used
  // and the result stays in order; operands are zero when idle.
  always_comb begin
    div_valid_out    = accept;
    div_dividend_out = '0;
    div_divisor_out  = '0;
    if (accept) begin
      if (req_dbz) begin
        div_dividend_out = '0;
        div_divisor_out  = WIDTH'(1);
      end else begin
        div_dividend_out = req_dividend_in;
        div_divisor_out  = req_divisor_in;
      end
    end
  end

  // Entry loaded into stage 0 of the tracking pipeline on accept.
  always_comb begin
    trk_in               = '0;
    trk_in.valid         = accept;
    trk_in.tag           = req_tag_in;
    trk_in.dbz           = req_dbz;
    trk_in.dividend_sign = req_dividend_in[WIDTH-1];
    trk_in.dividend      = req_dividend_in;
  end

  // Tracking pipeline, same depth as the divider; only the valid bits reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DIV_LATENCY; i++) trk_q[i].valid <= 1'b0;
    end else begin
      trk_q[0] <= trk_in;
      for (int i = 1; i < DIV_LATENCY; i++) trk_q[i] <= trk_q[i-1];
    end
  end

  assign trk_tail = trk_q[DIV_LATENCY-1];

  // Credit bookkeeping and registered ready. The blanking counter masks the
  // divider's output for DIV_LATENCY cycles after reset: the divider is not
  // reset and keeps draining work issued before it, which the now-empty
  // tracking pipeline no longer expects.
  always_comb begin
    credits_d = credits_q;
    case ({accept, pop})
      2'b10:   credits_d = credits_q + CRED_W'(1);
      2'b01:   credits_d = credits_q - CRED_W'(1);
      default: credits_d = credits_q;
    endcase
    req_ready_d = (credits_d < CRED_W'(FIFO_DEPTH));
    blank_d     = (blank_q != '0) ? blank_q - BLNK_W'(1) : blank_q;
    err_d       = err_q | ((blank_q == '0) & (trk_tail.valid != div_valid_in));
  end

  // Control registers: credits, ready, post-reset blanking and sticky error.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      credits_q   <= '0;
      req_ready_q <= 1'b0;
      blank_q     <= BLNK_W'(DIV_LATENCY);
      err_q       <= 1'b0;
    end else begin
      credits_q   <= credits_d;
      req_ready_q <= req_ready_d;
      blank_q     <= blank_d;
      err_q       <= err_d;
    end
  end

  // Result formation at the pipeline tail: divide-by-zero returns the
  // original dividend, otherwise the remainder magnitude takes the
  // dividend's sign.
  always_comb begin
    fifo_wr    = trk_tail.valid;
    fifo_wdata = '0;
    fifo_wdata.tag = trk_tail.tag;
    if (trk_tail.dbz) begin
      fifo_wdata.quotient  = '0;
      fifo_wdata.remainder = trk_tail.dividend;
      fifo_wdata.dbz       = 1'b1;
    end else begin
      fifo_wdata.quotient  = div_quotient_in;
      fifo_wdata.remainder = trk_tail.dividend_sign ? -div_remainder_in
                                                    : div_remainder_in;
      fifo_wdata.dbz       = 1'b0;
    end
  end

  resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_in),
    .rst_ni    (rst_n_in),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  assign unused_fifo_cnt   = ^fifo_cnt;
  assign rsp_valid_out     = ~fifo_empty;
  assign rsp_quotient_out  = fifo_rdata.quotient;
  assign rsp_remainder_out = fifo_rdata.remainder;
  assign rsp_tag_out       = fifo_rdata.tag;
  assign rsp_dbz_out       = fifo_rdata.dbz;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider, arithmetic reference model
// and a queue scoreboard of expected responses in issue order.
module tb_div_issue_ctrl;

  localparam int W = 32;
  localparam int TW = 8;
  localparam int L = 16;
  localparam int D = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n, req_valid, req_ready, rsp_ready, rsp_valid, err;
  logic signed [W-1:0] req_a, req_b, div_a, div_b, div_q, rsp_q, rsp_r;
  logic        [W-1:0] div_r;
  logic       [TW-1:0] req_tag, rsp_tag;
  logic                div_vo, div_vi, rsp_dbz;

  div_issue_ctrl #(.WIDTH(W), .TAG_W(TW), .DIV_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_dividend_in(req_a), .req_divisor_in(req_b), .req_tag_in(req_tag),
    .div_valid_out(div_vo), .div_dividend_out(div_a), .div_divisor_out(div_b),
    .div_valid_in(div_vi), .div_quotient_in(div_q), .div_remainder_in(div_r),
    .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready),
    .rsp_quotient_out(rsp_q), .rsp_remainder_out(rsp_r),
    .rsp_tag_out(rsp_tag), .rsp_dbz_out(rsp_dbz), .err_out(err)
  );

  // Behavioural divider: fixed latency, no reset, remainder as magnitude.
  logic [L-1:0]        dm_v;
  logic signed [W-1:0] dm_q [L];
  logic        [W-1:0] dm_r [L];
  logic signed [W-1:0] dm_q_in, dm_rtmp;
  logic        [W-1:0] dm_r_in;
  logic                dm_clr, spur;

  always_comb begin
    dm_q_in = '0;
    dm_rtmp = '0;
    dm_r_in = '0;
    if (div_b != 0) begin
      dm_q_in = div_a / div_b;
      dm_rtmp = div_a % div_b;
      dm_r_in = (dm_rtmp < 0) ? -dm_rtmp : dm_rtmp;
    end
  end

  always_ff @(posedge clk) begin
    if (dm_clr) dm_v <= '0;
    else        dm_v <= {dm_v[L-2:0], div_vo};
    dm_q[0] <= dm_q_in;
    dm_r[0] <= dm_r_in;
    for (int i = 1; i < L; i++) begin
      dm_q[i] <= dm_q[i-1];
      dm_r[i] <= dm_r[i-1];
    end
  end

  assign div_vi = dm_v[L-1] | spur;
  assign div_q  = dm_q[L-1];
  assign div_r  = dm_r[L-1];

  // Reference model and scoreboard.
  typedef struct {
    logic signed [W-1:0] q;
    logic signed [W-1:0] r;
    logic [TW-1:0]       tag;
    logic                dbz;
  } exp_t;

  exp_t expq[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_acc = 0, last_acc_cyc = 0, last_pop_cyc = 0, base = 0, k = 0, pre = 0;
  logic signed [W-1:0] last_q, last_r, hq, hr;
  logic [TW-1:0] last_tag, ht, tag_ctr;
  logic last_dbz, hd, hold_pend;

  function automatic exp_t model(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                 input logic [TW-1:0] t);
    exp_t e;
    e.tag = t;
    if (b == 0) begin
      e.q = 0; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", name, $signed(obs), obs,
             $signed(exp), exp);
    end
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", name, obs, exp);
    end
  endtask

  function automatic logic signed [W-1:0] rnd_val();
    logic signed [W-1:0] v;
    int iv;
    if ($urandom_range(0, 1) == 0) begin
      iv = int'($urandom_range(0, 2000)) - 1000;
      v  = iv;
    end else begin
      v = $urandom;
    end
    if (v == 32'sh8000_0000) v = 0;
    return v;
  endfunction

  task automatic rand_req();
    req_a   = rnd_val();
    req_b   = ($urandom_range(0, 7) == 0) ? 0 : rnd_val();
    req_tag = tag_ctr;
    tag_ctr = tag_ctr + 8'd1;
  endtask

  // One clock: observe at the falling edge, then advance past the rising edge.
  task automatic step();
    @(negedge clk);
    if (req_valid && req_ready) begin
      expq.push_back(model(req_a, req_b, req_tag));
      n_acc++;
      last_acc_cyc = cyc;
      chk1("issue_valid", div_vo, 1'b1);
      chk32("issue_dividend", div_a, (req_b == 0) ? 32'd0 : req_a);
      chk32("issue_divisor", div_b, (req_b == 0) ? 32'd1 : req_b);
    end else begin
      chk1("issue_idle", div_vo, 1'b0);
    end
    if (hold_pend && rst_n) begin
      chk32("hold_q", rsp_q, hq);
      chk32("hold_r", rsp_r, hr);
      chk32("hold_tag", 32'(rsp_tag), 32'(ht));
      chk1("hold_dbz", rsp_dbz, hd);
    end
    hold_pend = rst_n && rsp_valid && !rsp_ready;
    hq = rsp_q; hr = rsp_r; ht = rsp_tag; hd = rsp_dbz;
    if (rsp_valid && rsp_ready) begin
      chk1("rsp_expected", expq.size() != 0, 1'b1);
      if (expq.size() != 0) begin
        chk32("rsp_q", rsp_q, expq[0].q);
        chk32("rsp_r", rsp_r, expq[0].r);
        chk32("rsp_tag", 32'(rsp_tag), 32'(expq[0].tag));
        chk1("rsp_dbz", rsp_dbz, expq[0].dbz);
        void'(expq.pop_front());
      end
      last_q = rsp_q; last_r = rsp_r; last_tag = rsp_tag; last_dbz = rsp_dbz;
      last_pop_cyc = cyc;
    end
    chk1("fifo_no_overflow", dut.fifo_wr & dut.fifo_full, 1'b0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string name, input int max);
    int n;
    n = 0;
    while (expq.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk32(name, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; req_valid = 0; rsp_ready = 0; spur = 0; dm_clr = 1;
    req_a = 0; req_b = 0; req_tag = 0; tag_ctr = 8'd100; hold_pend = 0;
    hq = 0; hr = 0; ht = 0; hd = 0; last_q = 0; last_r = 0; last_tag = 0; last_dbz = 0;

    // Reset state
    repeat (3) step();
    chk1("rst_ready", req_ready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_err", err, 1'b0);
    dm_clr = 0;
    rst_n  = 1;
    step();
    chk1("ready_after_rst", req_ready, 1'b1);
    repeat (L + 2) step();

    // Single request 100/7, latency and values
    rsp_ready = 1;
    req_a = 100; req_b = 7; req_tag = 3; req_valid = 1;
    step();
    req_valid = 0;
    base = last_acc_cyc;
    drain("drain_single", 40);
    chk32("latency", 32'(last_pop_cyc - base), 32'(L + 1));
    chk32("t1_q", last_q, 32'd14);
    chk32("t1_r", last_r, 32'd2);
    chk32("t1_tag", 32'(last_tag), 32'd3);
    chk1("t1_dbz", last_dbz, 1'b0);

    // Sign combinations, back to back
    req_valid = 1;
    req_a = -100; req_b = 7;   req_tag = 10; step();
    req_a = 100;  req_b = -7;  req_tag = 11; step();
    req_a = -100; req_b = -7;  req_tag = 12; step();
    req_valid = 0;
    drain("drain_signs", 40);
    chk32("t2_last_q", last_q, 32'd14);
    chk32("t2_last_r", last_r, -32'sd2);
    chk32("t2_last_tag", 32'(last_tag), 32'd12);

    // Divide by zero
    req_a = 5; req_b = 0; req_tag = 9; req_valid = 1;
    step();
    req_valid = 0;
    drain("drain_dbz", 40);
    chk32("t3_q", last_q, 32'd0);
    chk32("t3_r", last_r, 32'd5);
    chk32("t3_tag", 32'(last_tag), 32'd9);
    chk1("t3_dbz", last_dbz, 1'b1);
    chk1("t3_err", err, 1'b0);

    // Credit limit with stalled responses, then drain
    rsp_ready = 0;
    base = n_acc;
    rand_req();
    req_valid = 1;
    for (int i = 0; i < 40; i++) begin
      pre = n_acc;
      step();
      if (n_acc != pre) rand_req();
    end
    chk32("t4_accepted", 32'(n_acc - base), 32'(D));
    chk1("t4_ready_low", req_ready, 1'b0);
    repeat (20) step();
    chk1("t4_rsp_valid", rsp_valid, 1'b1);
    chk1("t4_ready_still_low", req_ready, 1'b0);
    rsp_ready = 1;
    step();
    chk1("t4_ready_after_pop", req_ready, 1'b1);
    k = 0;
    while ((n_acc - base < 40 || expq.size() != 0) && k < 200) begin
      if (n_acc - base >= 40) req_valid = 0;
      pre = n_acc;
      step();
      if (n_acc != pre && n_acc - base < 40) rand_req();
      k++;
    end
    req_valid = 0;
    chk32("t4_total", 32'(n_acc - base), 32'd40);
    chk32("t4_drained", 32'(expq.size()), 32'd0);

    // Reset with work in flight
    base = n_acc;
    rand_req();
    req_valid = 1;
    k = 0;
    while (n_acc - base < 10 && k < 40) begin
      pre = n_acc;
      step();
      if (n_acc != pre) rand_req();
      k++;
    end
    rst_n = 0;
    #1;
    chk1("t5_ready", req_ready, 1'b0);
    chk1("t5_rsp_valid", rsp_valid, 1'b0);
    chk1("t5_div_valid", div_vo, 1'b0);
    chk1("t5_err", err, 1'b0);
    expq.delete();
    repeat (3) step();
    req_a = 9; req_b = 2; req_tag = 77;
    rst_n = 1;
    pre = n_acc;
    k = 0;
    while (n_acc == pre && k < 10) begin
      step();
      k++;
    end
    req_valid = 0;
    drain("drain_after_rst", 40);
    chk32("t5_q", last_q, 32'd4);
    chk32("t5_r", last_r, 32'd1);
    chk32("t5_tag", 32'(last_tag), 32'd77);
    repeat (40) step();
    chk1("t5_err_after", err, 1'b0);

    // Spurious divider valid with empty tracking pipeline
    spur = 1;
    chk1("t6_err_before_edge", err, 1'b0);
    step();
    spur = 0;
    chk1("t6_err_set", err, 1'b1);
    repeat (5) step();
    chk1("t6_err_sticky", err, 1'b1);
    rst_n = 0;
    #1;
    chk1("t6_err_cleared", err, 1'b0);
    step();
    rst_n = 1;
    repeat (L + 2) step();

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      rand_req();
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    req_valid = 0;
    rsp_ready = 1;
    drain("drain_random", 100);
    chk1("rand_err", err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
